mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory stage of the in-order RV32I core. It is the downstream consumer of the execute stage's enabled/completed handshake.
- Captures the executed instruction, the ALU result and rs2 when `enabled` pulses.
- Load/store: runs a request/ready transaction on the data-memory port.
- Other instructions: passes the ALU result through.
- Delivers the final rd value and instruction to writeback with a one-cycle `completed` pulse.

Parameters:
- ADDR_W, 32, data-memory byte-address width; `mem_addr` = low ADDR_W bits of the ALU result.
- MAX_WAIT, 255, ready-timeout bound in cycles; width of the wait counter = clog2(MAX_WAIT+1).

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- enabled  in  1  one-cycle pulse; instr/alu_rd/rs2 valid this cycle
- instr  in  instructions  executed instruction (pc, imm, lb/lh/lw/lbu/lhu/sb/sh/sw flags, rd index)
- alu_rd  in  32  execute result; effective address for loads/stores
- rs2  in  32  store data
- completed  out  1  one-cycle pulse; instr_out/rd_out valid
- instr_out  out  instructions  captured instruction
- rd_out  out  32  load result or alu_rd passthrough
- busy  out  1  high from capture until completed pulse inclusive
- timeout  out  1  sticky error; cleared only by rst
- mem_req  out  1  data-memory request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  byte address
- mem_wstrb  out  4  byte-lane strobes
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  request accepted/completed this cycle
- mem_rdata  in  32  read word, valid when mem_ready=1 and mem_we=0

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. completed, busy, timeout, mem_req, mem_we, mem_wstrb all 0. rd_out=0, mem_addr=0, mem_wdata=0, instr_out=all-zero.
- FSM states: IDLE, ACCESS, DONE.
- IDLE + enabled: capture instr, alu_rd, rs2; busy=1.
  - Load or store: go to ACCESS with mem_req=1 on the next cycle.
  - Other instruction: rd_out=alu_rd; go to DONE.
- ACCESS: mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata held stable until mem_ready=1 is sampled.
  - On that edge: loads register the extracted rd_out; stores set rd_out=alu_rd. mem_req drops and state goes to DONE.
- DONE: completed=1 for exactly one cycle, then IDLE with busy=0.
- Latency:
  - Non-memory: completed 2 cycles after enabled.
  - Memory: completed 1 cycle after the mem_ready edge. Zero-wait memory gives 3 cycles.
- enabled while busy=1: ignored. No capture, no state change.
- Store lanes, by addr[1:0]:
  - sb: wstrb = 0001 << a; wdata = {4{rs2[7:0]}}.
  - sh: wstrb = 0011 << a (a in {0,2}); wdata = {2{rs2[15:0]}}.
  - sw: wstrb = 1111.
- Load extraction:
  - lb/lbu: byte at rdata[8a+7:8a], sign-/zero-extended.
  - lh/lhu: half at rdata[8a+15:8a], sign-/zero-extended.
  - lw: full word.
- Misaligned access (feature off): addr[0] is ignored for halves; addr[1:0] is ignored for words. mem_addr always carries the full address.
- Timeout: a wait counter increments each ACCESS cycle with mem_ready=0.
  - On reaching MAX_WAIT: mem_req drops, timeout=1, rd_out=0, and state goes to DONE (completed still pulses).
- mem_ready outside ACCESS: ignored.
- rst mid-ACCESS: mem_req=0 on the next cycle and the transaction is abandoned. The memory model must tolerate the dropped request.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output `misaligned` (1 bit, one-cycle pulse coincident with completed).
  - lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, skip ACCESS. No mem_req is issued.
  - rd_out=alu_rd; go directly to DONE.
- Undefined: no `misaligned` port; the alignment handling above applies.

Decomposition:
- Shared package def: `instructions` typedef (gains is_load/is_store helper bits), width constants, mem_state_t enum {IDLE, ACCESS, DONE}.
- One sub-module, load_store_align: combinational wstrb/wdata generation and load extract/extend. It is reused by a future cache.

Test Plan:
- Non-memory: add, alu_rd=0x0000_0010, enabled pulse -> completed at +2 cycles, rd_out=0x10, mem_req never 1.
- sb: rs2=0x1234_56AB, addr=0x103, ready after 3 waits -> wstrb=1000, wdata=0xABABABAB, mem_req held 4 cycles, completed next cycle.
- Loads, rdata=0x80FF_7F01:
  - lb @0x...1 -> 0xFFFF_FF7F? No: byte1=0x7F -> 0x0000_007F.
  - lh @0x...2 -> 0xFFFF_80FF.
  - lhu @0x...2 -> 0x0000_80FF.
  - lbu @0x...3 -> 0x0000_0080.
- Timeout: MAX_WAIT=4, mem_ready stuck 0 -> mem_req low after 4 ACCESS cycles, timeout=1, rd_out=0, completed pulses.
- Back-to-back: enabled again while busy -> ignored. rst during ACCESS -> mem_req=0, busy=0, completed=0 next cycle.
- With MEM_MISALIGN_TRAP_EN: lw @0x102 -> misaligned=1 with completed, no mem_req, rd_out=0x102.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory stage: the instruction bundle, the
// memory-stage FSM states and small decode helpers.
package mem_access_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned STRB_W    = XLEN / 8;

  // Executed instruction as handed over by the execute stage.
  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic                 lb;
    logic                 lh;
    logic                 lw;
    logic                 lbu;
    logic                 lhu;
    logic                 sb;
    logic                 sh;
    logic                 sw;
    logic [REG_IDX_W-1:0] rd;
  } instructions;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  function automatic logic is_load(input instructions i);
    return i.lb | i.lh | i.lw | i.lbu | i.lhu;
  endfunction

  function automatic logic is_store(input instructions i);
    return i.sb | i.sh | i.sw;
  endfunction

  // Half accesses need addr[0]==0, word accesses need addr[1:0]==0.
  function automatic logic is_misaligned(input instructions i, input logic [1:0] a);
    return ((i.lh | i.lhu | i.sh) & a[0]) | ((i.lw | i.sw) & (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_load_store_align.sv
// Combinational byte-lane logic: store strobe/data replication and load
// extraction with sign/zero extension. Low address bits that do not fit the
// access size are ignored (halves use addr[1], words use lane 0).
module load_store_align
  import mem_access_pkg::*;
(
  input  logic [1:0]        i_addr_lo,
  input  logic              i_lb,
  input  logic              i_lh,
  input  logic              i_lbu,
  input  logic              i_lhu,
  input  logic              i_sb,
  input  logic              i_sh,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [STRB_W-1:0] o_wstrb,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]   o_load_data
);

  logic            w_byte_op;
  logic            w_half_op;
  logic [1:0]      w_lane;
  logic [XLEN-1:0] w_shifted;

  // Pick the effective lane, then build strobes, store data and load result.
  always_comb begin
    w_byte_op = i_lb | i_lbu | i_sb;
    w_half_op = i_lh | i_lhu | i_sh;
    if (w_byte_op)      w_lane = i_addr_lo;
    else if (w_half_op) w_lane = {i_addr_lo[1], 1'b0};
    else                w_lane = 2'b00;

    w_shifted = i_rdata >> {w_lane, 3'b000};

    o_wstrb = 4'b1111;
    o_wdata = i_wdata;
    if (i_sb) begin
      o_wstrb = 4'b0001 << w_lane;
      o_wdata = {4{i_wdata[7:0]}};
    end else if (i_sh) begin
      o_wstrb = 4'b0011 << w_lane;
      o_wdata = {2{i_wdata[15:0]}};
    end

    if (i_lb)       o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
    else if (i_lbu) o_load_data = {24'd0, w_shifted[7:0]};
    else if (i_lh)  o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
    else if (i_lhu) o_load_data = {16'd0, w_shifted[15:0]};
    else            o_load_data = i_rdata;
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage of the RV32I pipeline: captures an executed instruction,
// performs a request/ready data-memory transaction for loads and stores
// (with a ready timeout) and hands rd/instr to writeback with a one-cycle
// completed pulse. Optional macro MEM_MISALIGN_TRAP_EN adds a misaligned
// output and skips memory for misaligned halves/words.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enabled,
  input  instructions       instr,
  input  logic [XLEN-1:0]   alu_rd,
  input  logic [XLEN-1:0]   rs2,
  output logic              completed,
  output instructions       instr_out,
  output logic [XLEN-1:0]   rd_out,
  output logic              busy,
  output logic              timeout,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misaligned,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned     WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  mem_state_t        r_state;
  mem_state_t        w_next_state;
  instructions       r_instr;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_rs2;
  logic [XLEN-1:0]   r_rd;
  logic [WAIT_W-1:0] r_wait;
  logic              r_completed;
  logic              r_timeout;
  logic              w_capture;
  logic              w_go_mem;
  logic              w_wait_last;
  logic [STRB_W-1:0] w_wstrb;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_load_data;

  // completed is registered one cycle after DONE, so IDLE is not free to
  // accept until that pulse has gone.
  assign w_capture   = enabled && (r_state == IDLE) && !r_completed;
  assign w_wait_last = (r_wait == WAIT_LAST);

  // Decide whether the incoming instruction needs a memory transaction.
  always_comb begin
    w_go_mem = is_load(instr) || is_store(instr);
`ifdef MEM_MISALIGN_TRAP_EN
    if (is_misaligned(instr, alu_rd[1:0])) w_go_mem = 1'b0;
`endif
  end

  load_store_align u_align (
    .i_addr_lo   (r_addr[1:0]),
    .i_lb        (r_instr.lb),
    .i_lh        (r_instr.lh),
    .i_lbu       (r_instr.lbu),
    .i_lhu       (r_instr.lhu),
    .i_sb        (r_instr.sb),
    .i_sh        (r_instr.sh),
    .i_wdata     (r_rs2),
    .i_rdata     (mem_rdata),
    .o_wstrb     (w_wstrb),
    .o_wdata     (w_wdata),
    .o_load_data (w_load_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_next_state = w_go_mem ? ACCESS : DONE;
      ACCESS:  if (mem_ready || w_wait_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Memory-port outputs are driven only while in ACCESS.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wstrb = '0;
    if (r_state == ACCESS) begin
      mem_req = 1'b1;
      if (is_store(r_instr)) begin
        mem_we    = 1'b1;
        mem_wstrb = w_wstrb;
      end
    end
  end

  // Capture, result, wait counter, completion pulse and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr     <= '0;
      r_addr      <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_wait      <= '0;
      r_completed <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_completed <= (r_state == DONE);
      if (w_capture) begin
        r_instr <= instr;
        r_addr  <= alu_rd;
        r_rs2   <= rs2;
        r_wait  <= '0;
        if (!w_go_mem) r_rd <= alu_rd;
      end else if (r_state == ACCESS) begin
        if (mem_ready) begin
          r_rd <= is_load(r_instr) ? w_load_data : r_addr;
        end else if (w_wait_last) begin
          r_rd      <= '0;
          r_timeout <= 1'b1;
        end else begin
          r_wait <= r_wait + WAIT_W'(1);
        end
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_mis_pend;
  logic r_misaligned;

  // Remember a trapped capture and pulse misaligned alongside completed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mis_pend   <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= (r_state == DONE) && r_mis_pend;
      if (w_capture) r_mis_pend <= is_misaligned(instr, alu_rd[1:0]);
    end
  end

  assign misaligned = r_misaligned;
`endif

  assign completed = r_completed;
  assign busy      = (r_state != IDLE) || r_completed;
  assign timeout   = r_timeout;
  assign instr_out = r_instr;
  assign rd_out    = r_rd;
  assign mem_addr  = r_addr[ADDR_W-1:0];
  assign mem_wdata = w_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed and randomized loads/stores
// against a behavioural model of the byte-lane, latency and timeout rules.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int unsigned MAXW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enabled = 1'b0;
  instructions instr = '0;
  logic [31:0] alu_rd = '0;
  logic [31:0] rs2 = '0;
  logic        completed;
  instructions instr_out;
  logic [31:0] rd_out;
  logic        busy;
  logic        timeout;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int n_vec = 0;
  int n_err = 0;

  mem_access #(.ADDR_W(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .enabled(enabled), .instr(instr), .alu_rd(alu_rd), .rs2(rs2),
    .completed(completed), .instr_out(instr_out), .rd_out(rd_out), .busy(busy),
    .timeout(timeout),
`ifdef MEM_MISALIGN_TRAP_EN
    .misaligned(misaligned),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        stable;
    logic        busy_ok;
    logic        done;
    logic [31:0] rd;
    instructions iout;
    logic        to;
    logic        mis;
  } obs_t;

  // kind 0..7 = lb,lh,lw,lbu,lhu,sb,sh,sw; 8 = non-memory op
  function automatic instructions make_instr(input int kind);
    instructions i;
    i = '0;
    i.pc  = $urandom;
    i.imm = $urandom;
    i.rd  = 5'($urandom_range(0, 31));
    case (kind)
      0: i.lb = 1'b1;
      1: i.lh = 1'b1;
      2: i.lw = 1'b1;
      3: i.lbu = 1'b1;
      4: i.lhu = 1'b1;
      5: i.sb = 1'b1;
      6: i.sh = 1'b1;
      7: i.sw = 1'b1;
      default: ;
    endcase
    return i;
  endfunction

  // Reference model: expected result, lanes, latency and request length.
  function automatic void model(input instructions i, input logic [31:0] alu, input logic [31:0] rv,
                                input logic [31:0] rdata, input int waits,
                                output logic [31:0] e_rd, output logic [3:0] e_strb,
                                output logic [31:0] e_wdata, output int e_lat, output int e_req,
                                output logic e_to, output logic e_mis);
    int unsigned off;
    logic [31:0] b, h;
    logic ld, st, mem;
    off = alu % 4;
    ld  = i.lb | i.lh | i.lw | i.lbu | i.lhu;
    st  = i.sb | i.sh | i.sw;
    mem = ld | st;
    e_mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if (((i.lh | i.lhu | i.sh) && (off % 2 != 0)) || ((i.lw | i.sw) && off != 0)) begin
      e_mis = 1'b1;
      mem   = 1'b0;
    end
`endif
    if (i.lh | i.lhu | i.sh) off = (off / 2) * 2;
    if (i.lw | i.sw) off = 0;
    e_strb  = 4'h0;
    e_wdata = rv;
    if (i.sb) begin e_strb = 4'(1 << off); e_wdata = 32'(rv[7:0]) * 32'h0101_0101; end
    if (i.sh) begin e_strb = 4'(3 << off); e_wdata = 32'(rv[15:0]) * 32'h0001_0001; end
    if (i.sw) e_strb = 4'hF;
    e_to = 1'b0;
    if (!mem) begin
      e_rd = alu; e_lat = 2; e_req = 0;
    end else if (waits >= int'(MAXW)) begin
      e_rd = 32'd0; e_lat = MAXW + 2; e_req = MAXW; e_to = 1'b1;
    end else begin
      e_req = waits + 1;
      e_lat = 3 + waits;
      b = (rdata >> (8 * off)) & 32'hFF;
      h = (rdata >> (8 * off)) & 32'hFFFF;
      if (i.lb)       e_rd = (b >= 128) ? b - 32'd256 : b;
      else if (i.lbu) e_rd = b;
      else if (i.lh)  e_rd = (h >= 32768) ? h - 32'd65536 : h;
      else if (i.lhu) e_rd = h;
      else if (i.lw)  e_rd = rdata;
      else            e_rd = alu;
    end
  endfunction

  // Drive one transaction and act as a memory with the given wait count.
  task automatic run_txn(input instructions ins, input logic [31:0] alu, input logic [31:0] rv,
                         input logic [31:0] rdata, input int waits, input bit spam, output obs_t o);
    o.lat = 0; o.req = 0; o.we = 0; o.addr = 0; o.wstrb = 0; o.wdata = 0;
    o.stable = 1; o.busy_ok = 1; o.done = 0; o.rd = 0; o.iout = '0; o.to = 0; o.mis = 0;
    @(negedge clk);
    enabled = 1'b1; instr = ins; alu_rd = alu; rs2 = rv; mem_ready = 1'b0; mem_rdata = $urandom;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      enabled = spam; instr = make_instr($urandom_range(0, 8)); alu_rd = $urandom; rs2 = $urandom;
      if (busy !== 1'b1) o.busy_ok = 1'b0;
      if (mem_req === 1'b1) begin
        o.req++;
        if (o.req == 1) begin
          o.we = mem_we; o.addr = mem_addr; o.wstrb = mem_wstrb; o.wdata = mem_wdata;
        end else if (mem_we !== o.we || mem_addr !== o.addr || mem_wstrb !== o.wstrb ||
                     (o.we && mem_wdata !== o.wdata)) begin
          o.stable = 1'b0;
        end
        mem_ready = (o.req == waits + 1);
        mem_rdata = mem_ready ? rdata : $urandom;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      if (completed === 1'b1) begin
        o.done = 1; o.lat = cyc; o.rd = rd_out; o.iout = instr_out; o.to = timeout;
`ifdef MEM_MISALIGN_TRAP_EN
        o.mis = misaligned;
`endif
        break;
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({completed, busy, timeout, mem_req, mem_we, mem_wstrb} !== 9'd0 || rd_out !== 32'd0 ||
        mem_addr !== 32'd0 || mem_wdata !== 32'd0 || instr_out !== '0) begin
      n_err++;
      $display("FAIL reset_state: got cmp=%b rd=%h addr=%h wdata=%h want all zero",
               {completed, busy, timeout, mem_req, mem_we, mem_wstrb}, rd_out, mem_addr, mem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_nonmem();
    obs_t o;
    instructions i;
    i = make_instr(8);
    run_txn(i, 32'h0000_0010, $urandom, $urandom, 0, 0, o);
    n_vec++;
    if (o.done !== 1'b1 || o.lat != 2 || o.rd !== 32'h10 || o.req != 0 || o.iout !== i) begin
      n_err++;
      $display("FAIL nonmem: got done=%b lat=%0d rd=%h req=%0d want 1/2/00000010/0",
               o.done, o.lat, o.rd, o.req);
    end
  endtask

  task automatic test_store_sb();
    obs_t o;
    run_txn(make_instr(5), 32'h0000_0103, 32'h1234_56AB, $urandom, 3, 0, o);
    n_vec++;
    if (o.wstrb !== 4'b1000 || o.wdata !== 32'hABAB_ABAB || o.we !== 1'b1 || o.addr !== 32'h103) begin
      n_err++;
      $display("FAIL sb_lanes: got strb=%b wdata=%h we=%b addr=%h want 1000/abababab/1/00000103",
               o.wstrb, o.wdata, o.we, o.addr);
    end
    n_vec++;
    if (o.req != 4 || o.lat != 6 || o.stable !== 1'b1 || o.rd !== 32'h103) begin
      n_err++;
      $display("FAIL sb_timing: got req=%0d lat=%0d stable=%b rd=%h want 4/6/1/00000103",
               o.req, o.lat, o.stable, o.rd);
    end
  endtask

  task automatic test_loads();
    int          kinds[4] = '{0, 1, 4, 3};
    logic [31:0] addrs[4] = '{32'h2001, 32'h2002, 32'h2002, 32'h2003};
    logic [31:0] exps[4]  = '{32'h0000_007F, 32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_0080};
    obs_t o;
    int w;
    for (int k = 0; k < 4; k++) begin
      w = $urandom_range(0, 3);
      run_txn(make_instr(kinds[k]), addrs[k], $urandom, 32'h80FF_7F01, w, 0, o);
      n_vec++;
      if (o.rd !== exps[k] || o.lat != 3 + w || o.we !== 1'b0 || o.wstrb !== 4'h0) begin
        n_err++;
        $display("FAIL load_%0d: got rd=%h lat=%0d we=%b strb=%b want %h/%0d/0/0000",
                 k, o.rd, o.lat, o.we, o.wstrb, exps[k], 3 + w);
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    instructions i;
    logic [31:0] alu, rv, rdata, e_rd, e_wdata;
    logic [3:0] e_strb;
    logic e_to, e_mis, st;
    int e_lat, e_req, w;
    for (int n = 0; n < 40; n++) begin
      i = make_instr($urandom_range(0, 8));
      alu = $urandom; rv = $urandom; rdata = $urandom;
      w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 5);
      st = i.sb | i.sh | i.sw;
      model(i, alu, rv, rdata, w, e_rd, e_strb, e_wdata, e_lat, e_req, e_to, e_mis);
      run_txn(i, alu, rv, rdata, w, 0, o);
      n_vec++;
      if (o.done !== 1'b1 || o.lat != e_lat || o.req != e_req || o.rd !== e_rd ||
          o.iout !== i || o.to !== e_to || o.mis !== e_mis || o.busy_ok !== 1'b1) begin
        n_err++;
        $display("FAIL rand_%0d result: got lat=%0d req=%0d rd=%h to=%b mis=%b busy=%b want %0d/%0d/%h/%b/%b/1",
                 n, o.lat, o.req, o.rd, o.to, o.mis, o.busy_ok, e_lat, e_req, e_rd, e_to, e_mis);
      end
      if (o.req > 0) begin
        n_vec++;
        if (o.we !== st || o.addr !== alu || o.wstrb !== e_strb || o.stable !== 1'b1 ||
            (st && o.wdata !== e_wdata)) begin
          n_err++;
          $display("FAIL rand_%0d port: got we=%b addr=%h strb=%b wdata=%h stable=%b want %b/%h/%b/%h/1",
                   n, o.we, o.addr, o.wstrb, o.wdata, o.stable, st, alu, e_strb, e_wdata);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    instructions i;
    i = make_instr(2);
    run_txn(i, 32'h0000_4008, $urandom, 32'hCAFE_F00D, 2, 1, o);
    n_vec++;
    if (o.rd !== 32'hCAFE_F00D || o.iout !== i || o.req != 3 || o.lat != 5) begin
      n_err++;
      $display("FAIL b2b_ignore: got rd=%h req=%0d lat=%0d want cafef00d/3/5", o.rd, o.req, o.lat);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      enabled = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || completed !== 1'b0 || mem_req !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_idle_%0d: got busy=%b completed=%b req=%b want 0/0/0", c, busy, completed, mem_req);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(make_instr(2), 32'h0000_5000, $urandom, $urandom, 1000, 0, o);
    n_vec++;
    if (o.done !== 1'b1 || o.req != int'(MAXW) || o.lat != int'(MAXW) + 2 || o.rd !== 32'd0 || o.to !== 1'b1) begin
      n_err++;
      $display("FAIL timeout: got done=%b req=%0d lat=%0d rd=%h to=%b want 1/%0d/%0d/0/1",
               o.done, o.req, o.lat, o.rd, o.to, MAXW, MAXW + 2);
    end
    run_txn(make_instr(8), 32'h0000_0077, $urandom, $urandom, 0, 0, o);
    n_vec++;
    if (o.to !== 1'b1 || o.rd !== 32'h77) begin
      n_err++;
      $display("FAIL timeout_sticky: got to=%b rd=%h want 1/00000077", o.to, o.rd);
    end
  endtask

  task automatic test_rst_mid_access();
    obs_t o;
    int guard;
    @(negedge clk);
    enabled = 1'b1; instr = make_instr(7); alu_rd = 32'h0000_6004; rs2 = $urandom;
    @(negedge clk);
    enabled = 1'b0;
    guard = 0;
    while (mem_req !== 1'b1 && guard < 5) begin @(negedge clk); guard++; end
    n_vec++;
    if (mem_req !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_req: got mem_req=%b want 1", mem_req);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || completed !== 1'b0 || timeout !== 1'b0 ||
        rd_out !== 32'd0 || instr_out !== '0 || mem_wstrb !== 4'h0) begin
      n_err++;
      $display("FAIL rst_mid: got req=%b busy=%b cmp=%b to=%b rd=%h strb=%b want 0/0/0/0/0/0",
               mem_req, busy, completed, timeout, rd_out, mem_wstrb);
    end
    run_txn(make_instr(8), 32'h0000_0099, $urandom, $urandom, 0, 0, o);
    n_vec++;
    if (o.lat != 2 || o.rd !== 32'h99) begin
      n_err++;
      $display("FAIL after_rst: got lat=%0d rd=%h want 2/00000099", o.lat, o.rd);
    end
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    obs_t o;
    run_txn(make_instr(2), 32'h0000_0102, $urandom, $urandom, 0, 0, o);
    n_vec++;
    if (o.mis !== 1'b1 || o.req != 0 || o.rd !== 32'h102 || o.lat != 2) begin
      n_err++;
      $display("FAIL misalign_lw: got mis=%b req=%0d rd=%h lat=%0d want 1/0/00000102/2",
               o.mis, o.req, o.rd, o.lat);
    end
    run_txn(make_instr(7), 32'h0000_0104, $urandom, $urandom, 0, 0, o);
    n_vec++;
    if (o.mis !== 1'b0 || o.req != 1) begin
      n_err++;
      $display("FAIL aligned_sw: got mis=%b req=%0d want 0/1", o.mis, o.req);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nonmem();
    test_store_sb();
    test_loads();
    test_random();
    test_back_to_back();
`ifdef MEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_timeout();
    test_rst_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
